csa_sbox_stage: RTL and testbench
=================================

# csa_sbox_stage

Registered tap-and-combine stage of the CSA stream cipher. It takes a 40-bit snapshot of state register A, extracts the seven 5-bit S-box inputs using the fixed tap map, and drives the seven 5-in/2-out CSA S-boxes (sbox1..sbox7). It packs their 14 output bits into the X, Y, Z nibbles and the p, q bits consumed by the stream update logic. A valid/ready handshake sits on both sides so the stage can stall with the cipher core.

## Interface
Parameters:
- none; all widths are fixed by the algorithm.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous flush; drops every held result
- in_valid  in  1  a_in is valid this cycle
- in_ready  out  1  stage accepts a_in this cycle
- a_in  in  40  register A; nibble A(i+1) = a_in[4i+3:4i], i = 0..9
- out_valid  out  1  x/y/z/p/q hold a result
- out_ready  in  1  downstream accepts the result
- x, y, z  out  4 each  combined S-box nibbles
- p, q  out  1 each  carry/control bits

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- S-box inputs are listed MSB first (bit4..bit0):
  - s1: a[12], a[2], a[21], a[27], a[32]
  - s2: a[5], a[10], a[23], a[24], a[33]
  - s3: a[3], a[4], a[17], a[19], a[22]
  - s4: a[11], a[1], a[7], a[14], a[28]
  - s5: a[18], a[15], a[20], a[29], a[34]
  - s6: a[9], a[13], a[16], a[26], a[35]
  - s7: a[6], a[8], a[25], a[30], a[31]
- a_in[39:36] (nibble A10) is unused.
- Each sboxN output oN[1:0] is combined as follows:
  - x = {o4[0], o3[0], o2[1], o1[1]}
  - y = {o6[0], o5[0], o4[1], o3[1]}
  - z = {o2[0], o1[0], o6[1], o5[1]}
  - p = o7[1], q = o7[0]
- The S-box lookups and combining are combinational; only the packed 14-bit result is stored, and results are stored in acceptance order.
- While out_valid=1 and out_ready=0, x/y/z/p/q stay stable.
- clr takes priority over a simultaneous input or output transfer.
  - It empties all storage and forces out_valid=0 on the next cycle.
  - An input offered in the clr cycle is discarded.
- Reset state, also entered asynchronously mid-operation: out_valid=0 and x=y=z=0, p=q=0. in_ready follows the Configuration rules.

## Timing
- Latency from input transfer to out_valid is 1 cycle: data accepted at edge n is visible after edge n.
- Throughput is 1 result per cycle while out_ready=1.
- Stall:
  - A 1-entry stage cannot accept input while full and out_ready=0.
  - A simultaneous output and input transfer on a full 1-entry stage is legal and keeps out_valid=1.
- in_ready does not depend on in_valid.

## Configuration
- CSA_SBOX_SKID_EN defined: 2-entry skid buffer.
  - in_ready is a register output, equal to !(entry count == 2).
  - Back-to-back input with out_ready toggling loses no data and has no combinational out_ready->in_ready path.
- CSA_SBOX_SKID_EN undefined: single output register.
  - in_ready = !out_valid || out_ready, combinational.
- In both variants in_ready is 1 during reset. Data values and latency are identical in both.

## Structure
- Package csa_pkg holds:
  - the seven S-box tap index tables as localparam arrays
  - the result struct csa_xyz_t {x, y, z, p, q}
  - SBOX_IN_W=5 and SBOX_OUT_W=2
- Natural sub-module: csa_sbox_tap, a combinational 40-bit-in to 14-bit-out block. It instantiates sbox1..sbox7 and applies the tap and combine maps.
- csa_sbox_stage wraps csa_sbox_tap with the handshake and storage.

## Test plan
- Reset then a_in=40'h0000000000: o1=2'h2, so x[0]=1 and z[2]=0 one cycle after acceptance, and out_valid=1.
- a_in with only bits 12 and 27 set: s1 input=5'h12, o1=2'h3, so x[0]=1, z[2]=1. Compare every other bit against the sbox2..7 golden outputs for input 0.
- Stream 8 random a_in values with out_ready held at 0 from cycle 2:
  - Skid variant: in_ready drops after 2 accepted.
  - Non-skid variant: in_ready drops after 1 accepted.
  - After out_ready is released, all results emerge in order with none lost or duplicated.
- out_ready toggling 1/0 every cycle with continuous in_valid: the output sequence equals the reference model sequence, and x/y/z/p/q are stable during every stalled cycle.
- clr asserted while full together with in_valid=1: out_valid=0 next cycle, the offered input is dropped, and the following accepted input is the next output.
- rst asserted asynchronously mid-stream, between edges: out_valid and all outputs read 0 immediately. After rst deasserts, the first accepted a_in produces a correct result after 1 cycle.

Source files
------------

// File: rtl/csa_pkg.sv
// csa_pkg: shared constants and types for the CSA S-box stage.
//   SBOX_IN_W / SBOX_OUT_W : S-box input/output widths (5 in, 2 out)
//   SBOX_TAP               : per-S-box bit indices into register A, listed MSB first
//   SBOX_LUT               : CSA S-box truth tables sbox1..sbox7, indexed by 5-bit input
//   csa_xyz_t              : packed result {x, y, z, p, q}, 14 bits
package csa_pkg;

    localparam int unsigned SBOX_IN_W  = 5;
    localparam int unsigned SBOX_OUT_W = 2;
    localparam int unsigned N_SBOX     = 7;
    localparam int unsigned A_W        = 40;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] z;
        logic       p;
        logic       q;
    } csa_xyz_t;

    // Row n holds the taps of sbox(n+1); column 0 feeds input bit 4.
    localparam int unsigned SBOX_TAP [N_SBOX][SBOX_IN_W] = '{
        '{12,  2, 21, 27, 32},
        '{ 5, 10, 23, 24, 33},
        '{ 3,  4, 17, 19, 22},
        '{11,  1,  7, 14, 28},
        '{18, 15, 20, 29, 34},
        '{ 9, 13, 16, 26, 35},
        '{ 6,  8, 25, 30, 31}
    };

    localparam int unsigned SBOX_LUT [N_SBOX][32] = '{
        '{2,0,1,1,2,3,3,0, 3,2,2,0,1,1,0,3, 0,3,3,0,2,2,1,1, 2,2,0,3,1,1,3,0},
        '{3,1,0,2,2,3,3,0, 1,3,2,1,0,0,1,2, 3,1,0,3,3,2,0,2, 0,0,1,2,2,1,3,1},
        '{2,0,1,2,2,3,3,1, 1,1,0,3,3,0,2,0, 1,3,0,1,3,0,2,2, 2,0,1,2,0,3,3,1},
        '{3,1,2,3,0,2,1,2, 1,2,0,1,3,0,0,3, 1,0,3,1,2,3,0,3, 0,3,2,0,1,2,2,1},
        '{2,0,0,1,3,2,3,2, 0,1,3,3,1,0,2,1, 2,3,2,0,0,3,1,1, 1,0,3,2,3,1,0,2},
        '{0,1,2,3,1,2,2,0, 0,1,3,0,2,3,1,3, 2,3,0,2,3,0,1,1, 2,1,1,2,0,3,3,0},
        '{0,3,2,2,3,0,0,1, 3,0,1,3,1,2,2,1, 1,0,3,3,0,1,1,2, 2,3,1,0,2,3,0,2}
    };

endpackage

// File: rtl/csa_sbox_stage_if.sv
// csa_sbox_stage_if: handshake bundle of the CSA S-box stage.
//   in_valid/in_ready/a_in           : upstream side, 40-bit register A snapshot
//   out_valid/out_ready/x/y/z/p/q    : downstream side, combined S-box result
//   modport slave  : the stage
//   modport master : the environment driving and consuming the stage
interface csa_sbox_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [39:0] a_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [3:0]  z;
    logic        p;
    logic        q;

    modport slave (
        input  in_valid, a_in, out_ready,
        output in_ready, out_valid, x, y, z, p, q
    );

    modport master (
        output in_valid, a_in, out_ready,
        input  in_ready, out_valid, x, y, z, p, q
    );

endinterface

// File: rtl/csa_sbox_tap.sv
// csa_sbox_tap: combinational tap/S-box/combine block.
//   i_a   : 40-bit register A (bits 0 and 39:36 are not tapped)
//   o_res : {x, y, z, p, q} built from the 14 S-box output bits
module csa_sbox_tap
    import csa_pkg::*;
(
    input  logic [A_W-1:0] i_a,
    output csa_xyz_t       o_res
);

    logic [SBOX_IN_W-1:0]  w_sin  [N_SBOX];
    logic [SBOX_OUT_W-1:0] w_sout [N_SBOX];
    logic                  w_unused;

    for (genvar n = 0; n < N_SBOX; n++) begin : g_sbox
        for (genvar b = 0; b < SBOX_IN_W; b++) begin : g_tap
            // Tap table is MSB first, so column b drives bit (4 - b).
            assign w_sin[n][SBOX_IN_W-1-b] = i_a[SBOX_TAP[n][b]];
        end
        assign w_sout[n] = SBOX_OUT_W'(SBOX_LUT[n][w_sin[n]]);
    end

    assign o_res.x = {w_sout[3][0], w_sout[2][0], w_sout[1][1], w_sout[0][1]};
    assign o_res.y = {w_sout[5][0], w_sout[4][0], w_sout[3][1], w_sout[2][1]};
    assign o_res.z = {w_sout[1][0], w_sout[0][0], w_sout[5][1], w_sout[4][1]};
    assign o_res.p = w_sout[6][1];
    assign o_res.q = w_sout[6][0];

    assign w_unused = ^{i_a[39:36], i_a[0]};

endmodule

// File: rtl/csa_sbox_stage.sv
// csa_sbox_stage: registered CSA S-box tap-and-combine stage with valid/ready.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset (outputs and out_valid cleared)
//   clr : synchronous flush, wins over any same-cycle transfer
//   bus : csa_sbox_stage_if.slave (a_in in, x/y/z/p/q out, handshakes)
// Build option CSA_SBOX_SKID_EN: 2-entry skid buffer with registered in_ready;
// otherwise a single output register with in_ready = !out_valid || out_ready.
module csa_sbox_stage
    import csa_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    csa_sbox_stage_if.slave bus
);

    csa_xyz_t w_res;
    csa_xyz_t w_head;

    csa_sbox_tap u_tap (
        .i_a   (bus.a_in),
        .o_res (w_res)
    );

`ifdef CSA_SBOX_SKID_EN
    csa_xyz_t   r_mem [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;
    logic       r_in_ready;
    logic [1:0] w_count_nxt;
    logic       w_in_fire;
    logic       w_out_fire;

    assign w_in_fire  = bus.in_valid && r_in_ready && !clr;
    assign w_out_fire = (r_count != 2'd0) && bus.out_ready && !clr;

    always_comb begin
        w_count_nxt = r_count;
        if (w_in_fire && !w_out_fire) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_in_fire && w_out_fire) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // in_ready is computed from the next count so it is a pure register output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else if (clr) begin
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_in_fire) begin
                r_mem[r_wr_ptr] <= w_res;
                r_wr_ptr        <= !r_wr_ptr;
            end
            if (w_out_fire) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_count != 2'd0);
    assign w_head        = r_mem[r_rd_ptr];
`else
    csa_xyz_t r_data;
    logic     r_valid;

    assign bus.in_ready = !r_valid || bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (clr) begin
            r_valid <= 1'b0;
        end else if (bus.in_ready) begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_data <= w_res;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign w_head        = r_data;
`endif

    assign bus.x = w_head.x;
    assign bus.y = w_head.y;
    assign bus.z = w_head.z;
    assign bus.p = w_head.p;
    assign bus.q = w_head.q;

endmodule

// File: tb/tb_csa_sbox_stage.sv
// tb_csa_sbox_stage: directed self-checking bench for csa_sbox_stage.
// Expected results come from hand-computed constants and an independent
// bit-level reference of the CSA S-box tap/combine maps.
module tb_csa_sbox_stage;

    logic clk = 1'b0;
    logic rst;
    logic clr;

    csa_sbox_stage_if bus ();

    csa_sbox_stage u_dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef CSA_SBOX_SKID_EN
    localparam int unsigned EXP_FILL = 2;
`else
    localparam int unsigned EXP_FILL = 1;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_out    = 0;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    localparam int T [7][32] = '{
        '{2,0,1,1,2,3,3,0, 3,2,2,0,1,1,0,3, 0,3,3,0,2,2,1,1, 2,2,0,3,1,1,3,0},
        '{3,1,0,2,2,3,3,0, 1,3,2,1,0,0,1,2, 3,1,0,3,3,2,0,2, 0,0,1,2,2,1,3,1},
        '{2,0,1,2,2,3,3,1, 1,1,0,3,3,0,2,0, 1,3,0,1,3,0,2,2, 2,0,1,2,0,3,3,1},
        '{3,1,2,3,0,2,1,2, 1,2,0,1,3,0,0,3, 1,0,3,1,2,3,0,3, 0,3,2,0,1,2,2,1},
        '{2,0,0,1,3,2,3,2, 0,1,3,3,1,0,2,1, 2,3,2,0,0,3,1,1, 1,0,3,2,3,1,0,2},
        '{0,1,2,3,1,2,2,0, 0,1,3,0,2,3,1,3, 2,3,0,2,3,0,1,1, 2,1,1,2,0,3,3,0},
        '{0,3,2,2,3,0,0,1, 3,0,1,3,1,2,2,1, 1,0,3,3,0,1,1,2, 2,3,1,0,2,3,0,2}
    };

    function automatic logic [1:0] sb(input int n, input logic [4:0] i);
        return 2'(T[n][i]);
    endfunction

    function automatic logic [13:0] model(input logic [39:0] a);
        logic [1:0] o1, o2, o3, o4, o5, o6, o7;
        o1 = sb(0, {a[12], a[2],  a[21], a[27], a[32]});
        o2 = sb(1, {a[5],  a[10], a[23], a[24], a[33]});
        o3 = sb(2, {a[3],  a[4],  a[17], a[19], a[22]});
        o4 = sb(3, {a[11], a[1],  a[7],  a[14], a[28]});
        o5 = sb(4, {a[18], a[15], a[20], a[29], a[34]});
        o6 = sb(5, {a[9],  a[13], a[16], a[26], a[35]});
        o7 = sb(6, {a[6],  a[8],  a[25], a[30], a[31]});
        return {o4[0], o3[0], o2[1], o1[1],
                o6[0], o5[0], o4[1], o3[1],
                o2[0], o1[0], o6[1], o5[1],
                o7[1], o7[0]};
    endfunction

    logic [13:0] w_obs;
    assign w_obs = {bus.x, bus.y, bus.z, bus.p, bus.q};

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    logic [13:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [13:0] prev_obs   = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", 40'(w_obs), 40'(prev_obs));
            if (clr) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_extra_out", 40'(bus.out_valid), 40'd0);
                    end else begin
                        check("sb_data", 40'(w_obs), 40'(exp_q.pop_front()));
                        n_out++;
                    end
                end
                if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a_in));
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_obs   = w_obs;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer v until accepted; optionally toggle out_ready every cycle.
    task automatic offer(input logic [39:0] v, input bit toggle);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.a_in     = v;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready && !clr;
            cyc();
            if (toggle) bus.out_ready = !bus.out_ready;
        end
        check("offer_accept", 40'(acc), 40'd1);
    endtask

    task automatic check_result(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                                input logic [3:0] ez, input logic ep, input logic eq);
        @(negedge clk);
        check({tag, "_valid"}, 40'(bus.out_valid), 40'd1);
        check({tag, "_x"}, 40'(bus.x), 40'(ex));
        check({tag, "_y"}, 40'(bus.y), 40'(ey));
        check({tag, "_z"}, 40'(bus.z), 40'(ez));
        check({tag, "_p"}, 40'(bus.p), 40'(ep));
        check({tag, "_q"}, 40'(bus.q), 40'(eq));
    endtask

    logic [39:0] vals [10] = '{
        40'h12_3456_789A, 40'hFE_DCBA_9876, 40'h0F_0F0F_0F0F, 40'hA5_A5A5_A5A5,
        40'h00_0000_0001, 40'h7F_FFFF_FFFF, 40'h3C_C3C3_3C3C, 40'h55_AA55_AA55,
        40'h81_2481_2481, 40'hC0_FFEE_1234
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        int unsigned n0;

        rst = 1'b1;
        clr = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.out_ready = 1'b0;
        #2;
        check("rst_out_valid", 40'(bus.out_valid), 40'd0);
        check("rst_data", 40'(w_obs), 40'd0);
        check("rst_in_ready", 40'(bus.in_ready), 40'd1);
        cyc();
        rst = 1'b0;
        cyc();

        // Directed vectors with hand-computed results.
        bus.out_ready = 1'b1;
        offer(40'h00_0000_0000, 1'b0);
        bus.in_valid = 1'b0;
        check_result("zero", 4'hB, 4'h3, 4'h9, 1'b0, 1'b0);
        cyc();
        offer(40'h00_0800_1000, 1'b0);
        bus.in_valid = 1'b0;
        check_result("b12b27", 4'hB, 4'h3, 4'hD, 1'b0, 1'b0);
        cyc();
        offer(40'h00_8000_0000, 1'b0);
        bus.in_valid = 1'b0;
        check_result("b31", 4'hB, 4'h3, 4'h9, 1'b1, 1'b1);
        cyc();
        cyc();

        // Fill against a stalled output, then release.
        n0 = n_out;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        acc = 0;
        bus.a_in = vals[0];
        repeat (6) begin
            @(negedge clk);
            if (bus.in_ready) acc++;
            cyc();
            bus.a_in = vals[acc];
        end
        check("fill_count", 40'(acc), 40'(EXP_FILL));
        @(negedge clk);
        check("fill_in_ready", 40'(bus.in_ready), 40'd0);
        cyc();
        bus.out_ready = 1'b1;
        for (int i = int'(acc); i < 8; i++) offer(vals[i], 1'b0);
        bus.in_valid = 1'b0;
        repeat (4) cyc();
        check("stream_count", 40'(n_out - n0), 40'd8);

        // out_ready toggling with continuous input.
        n0 = n_out;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) offer(vals[9 - i], 1'b1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cyc();
        check("toggle_count", 40'(n_out - n0), 40'd10);

        // Flush while full with a simultaneous input offer.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a_in      = vals[1];
        repeat (3) cyc();
        clr      = 1'b1;
        bus.a_in = vals[2];
        cyc();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("clr_out_valid", 40'(bus.out_valid), 40'd0);
        cyc();
        n0 = n_out;
        bus.out_ready = 1'b1;
        offer(vals[3], 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("clr_next_valid", 40'(bus.out_valid), 40'd1);
        check("clr_next_data", 40'(w_obs), 40'(model(vals[3])));
        repeat (3) cyc();
        check("clr_count", 40'(n_out - n0), 40'd1);

        // Asynchronous reset between clock edges while holding a result.
        bus.out_ready = 1'b0;
        offer(vals[5], 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 40'(bus.out_valid), 40'd0);
        check("arst_data", 40'(w_obs), 40'd0);
        check("arst_in_ready", 40'(bus.in_ready), 40'd1);
        #3;
        rst = 1'b0;
        cyc();
        bus.out_ready = 1'b1;
        offer(vals[6], 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 40'(bus.out_valid), 40'd1);
        check("post_rst_data", 40'(w_obs), 40'(model(vals[6])));
        repeat (3) cyc();
        check("final_queue_empty", 40'(exp_q.size()), 40'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
